// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          FETCH_XLEN         = 32;
    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h8000_0000;
    localparam int          FETCH_PC_INC       = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Program counter register: redirect load wins over sequential increment.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int               XLEN         = FETCH_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = FETCH_RESET_VECTOR,
    parameter int               PC_INC       = FETCH_PC_INC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + XLEN'(PC_INC);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: req/gnt/rvalid to imem, valid/ready to decode.
// Optional FETCH_MISALIGN_CHECK_EN rejects redirects to non-word targets.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               XLEN         = FETCH_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = FETCH_RESET_VECTOR,
    parameter int               PC_INC       = FETCH_PC_INC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            misalign_err
`endif
);

    fetch_state_e state;
    logic         drop_pending;
    logic         redir;
    logic         pc_inc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misal;

    assign misal = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir = redirect_valid && !misal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= misal;
        end
    end
`else
    assign redir = redirect_valid;
`endif

    assign pc_inc = (state == S_WAIT) && imem_rvalid
                  && !drop_pending && !redir;

    pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR),
        .PC_INC       (PC_INC)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (pc_inc),
        .load   (redir),
        .target (redirect_pc),
        .pc     (pc_o)
    );

    // HOLD may issue the next fetch alongside the decode handshake,
    // but never for a fall-through address that a redirect is replacing.
    assign imem_req  = (state == S_REQ)
                     || ((state == S_HOLD) && instr_ready && !redir);
    assign imem_addr = pc_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            drop_pending <= 1'b0;
            instr_valid  <= 1'b0;
            instr_data   <= '0;
            instr_pc     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        state        <= S_WAIT;
                        drop_pending <= redir;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (redir || drop_pending) begin
                            drop_pending <= 1'b0;
                            state        <= S_REQ;
                        end else begin
                            instr_data  <= imem_rdata;
                            instr_pc    <= pc_o;
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else if (redir) begin
                        drop_pending <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        state <= S_REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state <= imem_gnt ? S_WAIT : S_REQ;
                    end
                end
            endcase
            if (redir && (state != S_IDLE)) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl plus multi-cycle corner cases.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_o;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int total  = 0;
    int passed = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_o           (pc_o)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] idat;
        logic        cd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic gnt, input logic rv, input logic [31:0] rdata,
        input logic rdy, input logic rd, input logic [31:0] rpc,
        input logic req, input logic [31:0] addr, input logic vld,
        input logic [31:0] pc, input logic [31:0] ipc,
        input logic [31:0] idat, input logic cd);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.rdy = rdy; v.rd = rd; v.rpc = rpc;
        v.req = req; v.addr = addr; v.vld = vld;
        v.pc = pc; v.ipc = ipc; v.idat = idat; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input vec_t v);
        imem_gnt       = v.gnt;
        imem_rvalid    = v.rv;
        imem_rdata     = v.rdata;
        instr_ready    = v.rdy;
        redirect_valid = v.rd;
        redirect_pc    = v.rpc;
    endtask

    initial begin
        vec_t idle;
        rst = 1'b0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);

        // table: one row per cycle, inputs applied, outputs checked pre-edge
        vq.push_back(mk(0,0,0,0,0,0, 0,0,0,32'h80000000,0,0,1));
        vq.push_back(mk(1,0,0,0,0,0, 1,32'h80000000,0,32'h80000000,0,0,0));
        vq.push_back(mk(0,1,32'h13,0,0,0, 0,0,0,32'h80000000,0,0,0));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(1,0,0,0,0,0, 0,0,1,32'h80000004,
                            32'h80000000,32'h13,1));
        vq.push_back(mk(1,0,0,1,0,0, 1,32'h80000004,1,32'h80000004,
                        32'h80000000,32'h13,1));
        vq.push_back(mk(0,1,32'h00100093,0,0,0, 0,0,0,32'h80000004,0,0,0));
        vq.push_back(mk(1,0,0,1,0,0, 1,32'h80000008,1,32'h80000008,
                        32'h80000004,32'h00100093,1));
        vq.push_back(mk(0,0,0,0,1,32'h80000100, 0,0,0,32'h80000008,0,0,0));
        vq.push_back(mk(0,1,32'hdeadbeef,0,0,0, 0,0,0,32'h80000100,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0, 1,32'h80000100,0,32'h80000100,0,0,0));
        vq.push_back(mk(0,1,32'h00200113,0,0,0, 0,0,0,32'h80000100,0,0,0));
        vq.push_back(mk(1,0,0,1,1,32'h80000200, 0,0,1,32'h80000104,
                        32'h80000100,32'h00200113,1));
        vq.push_back(mk(0,0,0,1,0,0, 1,32'h80000200,0,32'h80000200,0,0,0));
        vq.push_back(mk(1,0,0,0,1,32'hFFFFFFFC, 1,32'h80000200,0,
                        32'h80000200,0,0,0));
        vq.push_back(mk(0,1,32'h11111111,0,0,0, 0,0,0,32'hFFFFFFFC,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0, 1,32'hFFFFFFFC,0,32'hFFFFFFFC,0,0,0));
        vq.push_back(mk(0,1,32'h00300193,0,0,0, 0,0,0,32'hFFFFFFFC,0,0,0));
        vq.push_back(mk(1,0,0,1,0,0, 1,32'h00000000,1,32'h00000000,
                        32'hFFFFFFFC,32'h00300193,1));
        vq.push_back(mk(0,1,32'h22222222,0,1,32'h80000300, 0,0,0,
                        32'h00000000,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0, 1,32'h80000300,0,32'h80000300,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0, 1,32'h80000300,0,32'h80000300,0,0,0));
        vq.push_back(mk(0,1,32'h00400213,0,0,0, 0,0,0,32'h80000300,0,0,0));
        vq.push_back(mk(0,0,0,1,0,0, 1,32'h80000304,1,32'h80000304,
                        32'h80000300,32'h00400213,1));
        vq.push_back(mk(0,0,0,0,0,0, 1,32'h80000304,0,32'h80000304,0,0,0));

        @(negedge clk);
        #1;
        chk("rst_pc", pc_o, 32'h80000000);
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_ipc", instr_pc, 0);
        chk("rst_idata", instr_data, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #1;
            chk($sformatf("r%0d_req", i), {31'd0, imem_req}, {31'd0, vq[i].req});
            if (vq[i].req)
                chk($sformatf("r%0d_addr", i), imem_addr, vq[i].addr);
            chk($sformatf("r%0d_vld", i), {31'd0, instr_valid},
                {31'd0, vq[i].vld});
            chk($sformatf("r%0d_pc", i), pc_o, vq[i].pc);
            if (vq[i].cd) begin
                chk($sformatf("r%0d_ipc", i), instr_pc, vq[i].ipc);
                chk($sformatf("r%0d_idat", i), instr_data, vq[i].idat);
            end
            @(negedge clk);
        end

        // state is S_REQ at 80000304 with no grant yet
`ifdef FETCH_MISALIGN_CHECK_EN
        drive(idle);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000102;
        #1;
        chk("mis_req0", {31'd0, imem_req}, 1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("mis_err1", {31'd0, misalign_err}, 1);
        chk("mis_pc", pc_o, 32'h80000304);
        chk("mis_addr", imem_addr, 32'h80000304);
        @(negedge clk);
        #1;
        chk("mis_err0", {31'd0, misalign_err}, 0);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00500293;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        chk("mis_vld", {31'd0, instr_valid}, 1);
        chk("mis_ipc", instr_pc, 32'h80000304);
        chk("mis_pc2", pc_o, 32'h80000308);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
`else
        drive(idle);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000102;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("odd_req", {31'd0, imem_req}, 1);
        chk("odd_addr", imem_addr, 32'h80000102);
`endif

        // asynchronous reset while a request is in flight
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pc", pc_o, 32'h80000000);
        chk("arst_req", {31'd0, imem_req}, 0);
        chk("arst_vld", {31'd0, instr_valid}, 0);
        chk("arst_ipc", instr_pc, 0);

        // redirect during S_IDLE only moves the pc
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000400;
        #1;
        chk("idle_req", {31'd0, imem_req}, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("idle_req1", {31'd0, imem_req}, 1);
        chk("idle_addr", imem_addr, 32'h80000400);
        chk("idle_vld", {31'd0, instr_valid}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle core. Owns the program counter and issues one fetch request at a time to instruction memory over a req/gnt/rvalid handshake. Hands fetched words to decode over a valid/ready handshake. Applies branch, jump and trap redirects, and discards any response that was in flight when a redirect arrived.

Parameters:
XLEN, 32, address/data width
RESET_VECTOR, 32'h8000_0000, PC value loaded on reset
PC_INC, 4, byte increment for sequential fetch

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  XLEN  fetch address; stable while imem_req is high and imem_gnt is low
imem_gnt  input  1  memory accepted the request this cycle
imem_rvalid  input  1  read data valid; at most one per granted request, arriving at least 1 cycle after the grant
imem_rdata  input  XLEN  instruction word
instr_valid  output  1  instruction available to decode
instr_data  output  XLEN  instruction word
instr_pc  output  XLEN  PC of instr_data
instr_ready  input  1  decode accepts the instruction (low = stall)
redirect_valid  input  1  single-cycle pulse: change flow
redirect_pc  input  XLEN  redirect target
pc_o  output  XLEN  address of the current or next fetch

Behaviour:
- Reset (rst low, asynchronous):
  - pc_o = RESET_VECTOR
  - state = S_IDLE; imem_req = 0; instr_valid = 0
  - instr_data = 0; instr_pc = 0; drop_pending = 0
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD.
- S_IDLE: one cycle after reset release, then go to S_REQ. No request is issued while in S_IDLE.
- S_REQ:
  - imem_req = 1 and imem_addr = pc_o
  - On imem_gnt, go to S_WAIT.
  - Request/address must not change until granted, except on a redirect.
- S_WAIT:
  - imem_req = 0.
  - On imem_rvalid with drop_pending = 0: register instr_data = imem_rdata and instr_pc = pc_o, set instr_valid = 1, set pc_o = pc_o + PC_INC (mod 2^XLEN, wraps), go to S_HOLD.
  - On imem_rvalid with drop_pending = 1: discard the data, clear drop_pending, go to S_REQ.
- S_HOLD:
  - instr_valid = 1; instr_data and instr_pc are held stable.
  - When instr_ready = 1, the handshake completes. If imem_gnt is also high, issue the next request in the same cycle (go to S_WAIT). Otherwise go to S_REQ.
  - This gives back-to-back throughput of 1 instruction per 2 cycles with zero-wait memory.
- Redirect (highest priority, any state except S_IDLE):
  - pc_o = redirect_pc on the next edge; instr_valid drops to 0 on the next edge.
  - From S_REQ: the ungranted request is abandoned; stay in S_REQ with the new address.
  - From S_REQ with imem_gnt in the same cycle: the grant is treated as consumed. Set drop_pending = 1 and go to S_WAIT.
  - From S_WAIT: set drop_pending = 1 and stay in S_WAIT. If imem_rvalid arrives in the same cycle, drop it, then go to S_REQ.
  - From S_HOLD: the held instruction is squashed even if instr_ready = 1 that cycle; go to S_REQ.
- Redirect in S_IDLE: only pc_o is updated.
- Reset asserted mid-transaction: all state clears immediately. Memory is reset by the same rst, so no late rvalid is expected.
- Latency: redirect to imem_req with the new address is 1 cycle, or after the dropped rvalid if a request is in flight.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect_pc with bits [1:0] != 0 is not applied: pc_o is unchanged.
  - misalign_err pulses high for 1 cycle on the next edge.
  - The FSM continues as if no redirect occurred.
- Undefined: the port is absent; redirect_pc is applied unconditionally, with low bits passed through to imem_addr.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e enum (S_IDLE, S_REQ, S_WAIT, S_HOLD)
  - XLEN and RESET_VECTOR default constants
  - PC_INC constant
- Sub-module: pc_reg holds pc_o.
  - Async active-low reset to RESET_VECTOR.
  - Load inputs: increment enable and redirect load with target; redirect wins.
- FSM and handshake logic stay in fetch_ctrl.

Test Plan:
- Reset, then memory gnt = 1 and rvalid 1 cycle later with rdata = 32'h0000_0013, instr_ready = 1:
  - imem_addr = 80000000, then 80000004, then 80000008
  - instr_pc = 80000000, instr_data = 00000013
- Stall: hold instr_ready = 0 for 5 cycles → instr_valid stays 1 and instr_data/instr_pc are stable; no imem_req is issued; pc_o = 80000004.
- Redirect in S_WAIT to 80000100 → the late rdata is never presented; the next imem_addr = 80000100 and the next instr_pc = 80000100.
- Redirect in S_HOLD concurrently with instr_ready = 1 → that instruction is not counted as accepted; instr_valid = 0 next cycle; the next fetch is at the target.
- Wrap: redirect to FFFFFFFC, then a sequential fetch → the next imem_addr = 00000000.
- With FETCH_MISALIGN_CHECK_EN defined: redirect to 80000102 → misalign_err = 1 for 1 cycle; sequential fetch continues from the previous pc_o.
